// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm
// Frame sequencer for the UART transmitter: start bit, DATA_WIDTH data bits,
// optional parity bit, then stop bit(s). Drives the TX output-mux select
// and the serializer load/shift strobes.
// Build option: define UART_TX_TWO_STOP_EN to append a second stop bit (STOP2).

module uart_tx_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Data_Valid,
  input  logic       PAR_EN,
  output logic [1:0] mux_sel,
  output logic       ser_load,
  output logic       ser_en,
  output logic       busy
);

  // state  | meaning
  // IDLE   | line idle-high, waiting for a send request
  // START  | start bit on the mux (1 cycle)
  // DATA   | serial data bits, serializer shifting (DATA_WIDTH cycles)
  // PARITY | parity bit on the mux (1 cycle, only if captured parity enable)
  // STOP   | stop bit; last stop state unless the second stop bit is built in
  // STOP2  | second stop bit, present only with UART_TX_TWO_STOP_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
`ifdef UART_TX_TWO_STOP_EN
    ,
    STOP2  = 3'd5
`endif
  } state_t;

`ifdef UART_TX_TWO_STOP_EN
  localparam state_t LAST_STOP = STOP2;
`else
  localparam state_t LAST_STOP = STOP;
`endif

  // A 1-bit counter is kept even for DATA_WIDTH == 1 so the compare stays legal.
  localparam int                CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] bit_cnt;
  logic             par_en_r;
  logic             accept;

  // A request is only taken when the FSM is free: idle or finishing the last stop bit.
  assign accept = Data_Valid && ((state == IDLE) || (state == LAST_STOP));

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= next_state;
  end

  // Data bit counter: cleared in START so DATA always begins at bit 0.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                bit_cnt <= '0;
    else if (state == START) bit_cnt <= '0;
    else if (state == DATA)  bit_cnt <= bit_cnt + CNT_W'(1);
  end

  // Parity enable is frozen at accept so mid-frame PAR_EN changes cannot alter the frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)        par_en_r <= 1'b0;
    else if (accept) par_en_r <= PAR_EN;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:   next_state = accept ? START : IDLE;
      START:  next_state = DATA;
      DATA: begin
        if (bit_cnt == CNT_LAST) next_state = par_en_r ? PARITY : STOP;
        else                     next_state = DATA;
      end
      PARITY: next_state = STOP;
`ifdef UART_TX_TWO_STOP_EN
      STOP:   next_state = STOP2;
      STOP2:  next_state = accept ? START : IDLE;
`else
      STOP:   next_state = accept ? START : IDLE;
`endif
      default: next_state = IDLE;
    endcase
  end

  // Output decode: mux/shift/busy from state only; the load strobe also needs
  // the request and is forced low while reset is held.
  always_comb begin
    mux_sel  = 2'b01;
    ser_en   = 1'b0;
    busy     = (state != IDLE);
    ser_load = RST && accept;
    case (state)
      START:   mux_sel = 2'b00;
      DATA: begin
        mux_sel = 2'b10;
        ser_en  = 1'b1;
      end
      PARITY:  mux_sel = 2'b11;
      default: mux_sel = 2'b01;
    endcase
  end

endmodule

// File: doc/uart_tx_fsm.md
# uart_tx_fsm

Control state machine for the UART transmitter. It accepts a byte-send request and sequences the frame through the TX output mux: start bit, DATA_WIDTH data bits, optional parity bit, stop bit. It drives the mux select code and the serializer load/shift strobes. It sits between the upstream data source and the serializer / parity / output-mux datapath.

## Interface
- DATA_WIDTH, 8, data bits per frame; legal range 1..16.
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset, asynchronous, active-low.
- Data_Valid  input  1  upstream send request; data is held stable by upstream until accepted.
- PAR_EN  input  1  parity enable request, sampled only at accept.
- mux_sel  output  2  output mux select: 00 start, 01 stop/idle, 10 serial data, 11 parity.
- ser_load  output  1  combinational accept strobe; loads serializer and parity calculator this cycle.
- ser_en  output  1  serializer shift enable; high for every DATA-state cycle.
- busy  output  1  high while a frame is in progress (state != IDLE).

## Operation
- The block is a Moore FSM with states IDLE, START, DATA, PARITY, STOP, and STOP2 when STOP2 is compiled in. State is registered. mux_sel, ser_en and busy decode from the state only.
- mux_sel decode:
  - IDLE=01, START=00, DATA=10, PARITY=11, STOP/STOP2=01.
  - ser_en=1 only in DATA.
- Accept:
  - ser_load = Data_Valid & (state==IDLE or state==last stop state).
  - On accept, the current PAR_EN is captured into par_en_r and the next state is START.
- START lasts 1 cycle, then goes to DATA with bit counter cleared to 0.
- DATA lasts exactly DATA_WIDTH cycles:
  - The counter is $clog2(DATA_WIDTH) bits wide (min 1) and increments each cycle.
  - At count DATA_WIDTH-1, the next state is PARITY if par_en_r is set, else STOP.
- PARITY lasts 1 cycle, then goes to STOP.
- STOP (last stop state):
  - If Data_Valid, the request is accepted and the next state is START. Frames go back-to-back with no idle gap.
  - Otherwise the next state is IDLE.
- Data_Valid in START, DATA or PARITY is ignored; it is not accepted and no state effect occurs.
- PAR_EN changes mid-frame are ignored; only par_en_r is used.
- Reset, at any time and including mid-frame:
  - state=IDLE, counter=0, par_en_r=0.
  - Outputs: mux_sel=01, ser_en=0, busy=0.
  - ser_load=0 while RST is low.
  - The line returns to idle-high one cycle later through the registered mux.

## Timing
- Accept at cycle T (IDLE, Data_Valid=1) gives:
  - START at T+1.
  - DATA at T+2..T+1+W.
  - PARITY at T+2+W, if enabled.
  - STOP at the following cycle.
- busy is high for 2+W+P cycles, where P = par_en_r. For W=8 that is 11 cycles with parity and 10 without.
- The TX line lags mux_sel by exactly 1 cycle because the mux output is registered. The start bit appears on the line at T+2.
- Minimum Data_Valid to accept latency is 0 cycles in IDLE. Latency in a busy state is until the last stop state.
- ser_en pulses: exactly W per frame, contiguous.
- ser_load pulses: exactly 1 per frame.

## Configuration
- UART_TX_TWO_STOP_EN defined:
  - STOP2 is inserted after STOP. It is 1 cycle with mux_sel=01.
  - STOP2 becomes the last stop state, so the accept/back-to-back rule applies in STOP2, not STOP.
  - busy length becomes 3+W+P.
- UART_TX_TWO_STOP_EN undefined: STOP2 does not exist, and STOP goes directly to IDLE or START.

## Test plan
- Reset: RST low mid-DATA → same cycle mux_sel=01, busy=0, ser_en=0. After release, the FSM stays in IDLE with Data_Valid=0.
- Single frame, W=8, PAR_EN=1, Data_Valid pulse at T:
  - ser_load=1 at T.
  - mux_sel sequence: 00, 10×8, 11, 01.
  - busy high 11 cycles, ser_en high 8 cycles, IDLE at T+12.
- Single frame with PAR_EN=0 → no 11 code; busy 10 cycles.
- PAR_EN toggled 1→0 during DATA after accepting with PAR_EN=1 → the PARITY state is still entered.
- Data_Valid held high continuously for 3 frames → ser_load fires in IDLE and then in each STOP. There are no idle cycles between frames, and mux_sel goes 01→00 directly.
- Data_Valid asserted only during DATA and dropped before STOP → no accept, and the FSM returns to IDLE.
- With UART_TX_TWO_STOP_EN defined → two consecutive 01 cycles at frame end, busy 12 cycles (W=8, parity on), and back-to-back accept occurs in STOP2 only.
